mac_pipe: RTL and testbench

MAC_PIPE -- requirements
Module: mac_pipe

---
 rtl/mac_pipe.sv | 139 +++++++++++++
 tb/tb_mac_pipe.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_pipe.sv
// mac_pipe: pipelined multiply-accumulate with a ready/valid handshake on both sides.
//
// The operands are multiplied as signed or unsigned values, selected separately for
// each operand. The product passes through STAGES-1 product registers and then
// reaches the accumulator stage. The accumulator either loads the product or adds it
// to the running value. The whole pipeline stalls as one unit: every stage moves
// only when the output register is empty or its value is being taken.
//
// Parameters
//   WIDTH   operand width (4..32)
//   STAGES  input-to-output latency in cycles (2..4)
//   ACC_W   accumulator width (>= 2*WIDTH+1)
//
// Ports
//   sys_clk    clock, rising edge
//   sys_rst    synchronous active-high reset; takes priority over clr
//   clr        synchronous flush of the pipeline, the accumulator and ovf
//   in_valid   operand beat offered    / in_ready  beat accepted (global advance)
//   a, b       operands                / sign_a, sign_b  1 = two's complement
//   acc_en     1 = accumulate, 0 = load the product
//   out_valid  q valid                 / out_ready  downstream takes q
//   q          accumulator value       / ovf  sticky accumulator overflow
//
// Build option
//   MAC_PIPE_SATURATE_EN  when defined, an overflowing add clamps to the most
//                         positive or most negative ACC_W value. When undefined,
//                         the sum wraps. ovf is set in both builds.
module mac_pipe #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 2,
    parameter int ACC_W  = 2*WIDTH+8
) (
    input  logic             sys_clk,
    input  logic             sys_rst,
    input  logic             clr,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sign_a,
    input  logic             sign_b,
    input  logic             acc_en,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] q,
    output logic             ovf
);
    localparam int PW = 2*WIDTH;   // exact product width
    localparam int PS = STAGES-1;  // number of product stages

    typedef struct packed {
        logic [PW-1:0] prod;
        logic          sext;    // sign-extend the product into the accumulator
        logic          acc_en;
    } beat_t;

    beat_t   [PS-1:0] stg;
    logic    [PS-1:0] vld_pipe;
    logic [ACC_W-1:0] acc;

    logic                advance;
    logic signed [WIDTH:0] a_ext, b_ext;
    logic signed [PW-1:0]  prod;
    beat_t               new_beat;

    // One advance signal drives every stage, so a stall freezes the whole pipe.
    // Bubbles are not squeezed out.
    assign advance  = !out_valid || out_ready;
    assign in_ready = advance && !sys_rst && !clr;

    // Add one extension bit to each operand so that all four sign combinations
    // become one signed multiply. The low PW bits of that multiply hold the exact
    // product for every combination.
    assign a_ext = {sign_a & a[WIDTH-1], a};
    assign b_ext = {sign_b & b[WIDTH-1], b};
    assign prod  = a_ext * b_ext;

    assign new_beat = '{prod: prod, sext: sign_a | sign_b, acc_en: acc_en};

    // ---------------- accumulator stage datapath ----------------
    beat_t            last;
    logic [ACC_W-1:0] p_ext, sum, acc_nxt;
    logic             add_ovf;

    assign last  = stg[PS-1];
    assign p_ext = last.sext ? {{(ACC_W-PW){last.prod[PW-1]}}, last.prod}
                             : {{(ACC_W-PW){1'b0}}, last.prod};
    assign sum   = acc + p_ext;

    // A two's-complement add overflows when both addends have the same sign and
    // the sum has the other sign.
    assign add_ovf = last.acc_en && (acc[ACC_W-1] == p_ext[ACC_W-1])
                                 && (sum[ACC_W-1] != acc[ACC_W-1]);

    always_comb begin
        acc_nxt = sum;
        if (!last.acc_en) begin
            acc_nxt = p_ext;   // a loaded product always fits, because ACC_W > PW
        end else if (add_ovf) begin
`ifdef MAC_PIPE_SATURATE_EN
            // The sign of the addends gives the direction of the overflow.
            acc_nxt = acc[ACC_W-1] ? {1'b1, {(ACC_W-1){1'b0}}}
                                   : {1'b0, {(ACC_W-1){1'b1}}};
`else
            acc_nxt = sum;
`endif
        end
    end

    // ---------------- control and state ----------------
    always_ff @(posedge sys_clk) begin
        if (sys_rst || clr) begin
            vld_pipe  <= '0;
            out_valid <= 1'b0;
            acc       <= '0;
            ovf       <= 1'b0;
        end else if (advance) begin
            vld_pipe[0] <= in_valid;
            for (int i = 1; i < PS; i++) vld_pipe[i] <= vld_pipe[i-1];
            // The output register empties when its value is taken, unless a new
            // beat replaces it in the same cycle.
            out_valid <= vld_pipe[PS-1];
            if (vld_pipe[PS-1]) begin
                acc <= acc_nxt;
                if (add_ovf) ovf <= 1'b1;
            end
        end
    end

    // The payload needs no reset, because vld_pipe qualifies it.
    always_ff @(posedge sys_clk) begin
        if (advance) begin
            stg[0] <= new_beat;
            for (int i = 1; i < PS; i++) stg[i] <= stg[i-1];
        end
    end

    assign q = acc;
endmodule

// File: tb/tb_mac_pipe.sv
// Testbench for mac_pipe. Two instances share one stimulus stream:
//   u0: WIDTH=16, STAGES=2, ACC_W=40
//   u1: WIDTH=16, STAGES=2, ACC_W=33 (this width makes overflow easy to reach)
// A transaction-level model uses plain integer arithmetic to predict out_valid,
// in_ready, q and ovf for each instance, and a compare process checks these every
// cycle. Directed sections also check hand-computed literal values.
module tb_mac_pipe;
    localparam int ST = 2;

    logic clk = 1'b0;
    logic rst, clr, in_valid, sa, sb, en, out_ready;
    logic [15:0] a, b;
    logic in_ready0, out_valid0, ovf0, in_ready1, out_valid1, ovf1;
    logic [39:0] q0;
    logic [32:0] q1;

    int nchk = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    mac_pipe #(.WIDTH(16), .STAGES(ST), .ACC_W(40)) u0 (
        .sys_clk(clk), .sys_rst(rst), .clr(clr), .in_valid(in_valid), .in_ready(in_ready0),
        .a(a), .b(b), .sign_a(sa), .sign_b(sb), .acc_en(en),
        .out_valid(out_valid0), .out_ready(out_ready), .q(q0), .ovf(ovf0));

    mac_pipe #(.WIDTH(16), .STAGES(ST), .ACC_W(33)) u1 (
        .sys_clk(clk), .sys_rst(rst), .clr(clr), .in_valid(in_valid), .in_ready(in_ready1),
        .a(a), .b(b), .sign_a(sa), .sign_b(sb), .acc_en(en),
        .out_valid(out_valid1), .out_ready(out_ready), .q(q1), .ovf(ovf1));

    task automatic chk(input string nm, input longint act, input longint exp);
        nchk++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct { longint p; bit en; } mbeat_t;
    mbeat_t m_slot [2][ST-1];
    bit     m_sv   [2][ST-1];
    bit     m_ov   [2];
    bit     m_ovf  [2];
    longint m_acc  [2];
    bit     started = 0;

    function automatic int aw(input int i);
        return (i == 0) ? 40 : 33;
    endfunction

    function automatic longint mprod(input logic [15:0] x, input logic [15:0] y,
                                     input bit sx, input bit sy);
        longint xv, yv;
        xv = (sx && x[15]) ? longint'(x) - 65536 : longint'(x);
        yv = (sy && y[15]) ? longint'(y) - 65536 : longint'(y);
        return xv * yv;
    endfunction

    function automatic void acc_step(input longint acc, input longint p, input bit e,
                                     input int w, output longint res, output bit ov);
        longint one = 1;
        longint hi, lo, s;
        hi = (one <<< (w-1)) - 1;
        lo = -(one <<< (w-1));
        ov = 0;
        if (!e) res = p;
        else begin
            s = acc + p;
            if (s > hi || s < lo) begin
                ov = 1;
`ifdef MAC_PIPE_SATURATE_EN
                res = (s > hi) ? hi : lo;
`else
                res = (s > hi) ? s - (one <<< w) : s + (one <<< w);
`endif
            end else res = s;
        end
    endfunction

    initial forever begin
        @(posedge clk);
        for (int i = 0; i < 2; i++) begin
            if (rst || clr) begin
                m_ov[i] = 0; m_ovf[i] = 0; m_acc[i] = 0;
                for (int k = 0; k < ST-1; k++) m_sv[i][k] = 0;
            end else if (!m_ov[i] || out_ready) begin
                if (m_sv[i][ST-2]) begin
                    longint r; bit ov;
                    acc_step(m_acc[i], m_slot[i][ST-2].p, m_slot[i][ST-2].en, aw(i), r, ov);
                    m_acc[i] = r;
                    if (ov) m_ovf[i] = 1;
                    m_ov[i] = 1;
                end else m_ov[i] = 0;
                for (int k = ST-2; k > 0; k--) begin
                    m_slot[i][k] = m_slot[i][k-1];
                    m_sv[i][k]   = m_sv[i][k-1];
                end
                m_slot[i][0] = '{p: mprod(a, b, sa, sb), en: en};
                m_sv[i][0]   = in_valid;
            end
        end
        started = 1;
    end

    // ---------------- per-cycle compare ----------------
    initial forever begin
        @(negedge clk);
        if (started) begin
            for (int i = 0; i < 2; i++) begin
                longint one = 1;
                longint mask;
                bit exp_rdy;
                mask    = (one <<< aw(i)) - 1;
                exp_rdy = !rst && !clr && (!m_ov[i] || out_ready);
                chk($sformatf("u%0d out_valid", i), (i == 0) ? out_valid0 : out_valid1, m_ov[i]);
                chk($sformatf("u%0d in_ready", i),  (i == 0) ? in_ready0 : in_ready1, exp_rdy);
                chk($sformatf("u%0d ovf", i),       (i == 0) ? ovf0 : ovf1, m_ovf[i]);
                chk($sformatf("u%0d q", i), (i == 0) ? longint'(q0) : longint'(q1), m_acc[i] & mask);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic drive(input logic [15:0] x, input logic [15:0] y, input bit sx,
                         input bit sy, input bit e);
        a = x; b = y; sa = sx; sb = sy; en = e; in_valid = 1;
    endtask

    // Offer a single beat, wait until it is accepted, then wait for its result and
    // compare q against a literal value.
    task automatic send_wait(input logic [15:0] x, input logic [15:0] y, input bit sx,
                             input bit sy, input bit e, input longint exp, input string nm);
        bit got = 0;
        drive(x, y, sx, sy, e);
        for (int t = 0; t < 20 && !got; t++) begin
            @(negedge clk);
            if (in_ready0) got = 1;
            tick();
        end
        if (!got) chk({nm, " accept timeout"}, 0, 1);
        in_valid = 0;
        got = 0;
        for (int t = 0; t < 20 && !got; t++) begin
            @(negedge clk);
            if (out_valid0) begin
                chk(nm, longint'(q0), exp);
                got = 1;
            end
            tick();
        end
        if (!got) chk({nm, " result timeout"}, 0, 1);
    endtask

    // Load a signed-by-signed product, then accumulate it five more times into the
    // 33-bit instance. The fifth result (r == 4) is the first add that overflows.
    task automatic ovf_run(input logic [15:0] x, input logic [15:0] y,
                           input longint exp5, input string nm);
        clr = 1; tick(); clr = 0;
        for (int cyc = 0; cyc < 8; cyc++) begin
            if (cyc < 6) drive(x, y, 1, 1, cyc != 0);
            else in_valid = 0;
            @(negedge clk);
            if (cyc >= 2) begin
                chk({nm, " vld"}, out_valid1, 1);
                if (cyc - 2 < 4) chk({nm, " ovf clear"}, ovf1, 0);
                if (cyc - 2 == 4) begin
                    chk({nm, " ovf set"}, ovf1, 1);
                    chk({nm, " q"}, longint'(q1), exp5);
                end
            end
            tick();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1; clr = 0; in_valid = 0; a = 0; b = 0; sa = 0; sb = 0; en = 0; out_ready = 1;
        tick(); tick();
        @(negedge clk);
        chk("reset q", longint'(q0), 0);
        chk("reset in_ready", in_ready0, 0);
        tick();
        rst = 0;

        // Sign modes: the result of each load is pinned to a literal value.
        send_wait(16'hFFFF, 16'h0002, 0, 0, 0, 64'h1FFFE,       "uu");
        send_wait(16'hFFFF, 16'h0002, 1, 1, 0, 64'hFFFFFFFFFE,  "ss");
        send_wait(16'hFFFF, 16'h0002, 1, 0, 0, 64'hFFFFFFFFFE,  "su");
        send_wait(16'hFFFF, 16'h0002, 0, 1, 0, 64'h1FFFE,       "us");
        send_wait(16'h8000, 16'h8000, 1, 1, 0, 64'h40000000,    "ss min*min");
        send_wait(16'h8000, 16'hFFFF, 1, 0, 0, 64'hFF80008000,  "su min*max");

        // Back-to-back beats: results appear in cycles N+2..N+5.
        for (int cyc = 0; cyc < 6; cyc++) begin
            if (cyc < 4) drive(3, 4, 0, 0, cyc != 0);
            else in_valid = 0;
            @(negedge clk);
            if (cyc >= 2) begin
                chk("b2b vld", out_valid0, 1);
                chk("b2b q", longint'(q0), 12 * (cyc - 1));
            end else chk("b2b vld early", out_valid0, 0);
            tick();
        end

        // Stall: 2*5 (load), then +1*1 and +1*2, with out_ready low for 3 cycles.
        out_ready = 0;
        drive(2, 5, 0, 0, 0); tick();
        drive(1, 1, 0, 0, 1); tick();
        drive(1, 2, 0, 0, 1);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("stall vld", out_valid0, 1);
            chk("stall q", longint'(q0), 10);
            chk("stall in_ready", in_ready0, 0);
            tick();
        end
        out_ready = 1;
        @(negedge clk); chk("release q", longint'(q0), 10); tick();
        in_valid = 0;
        @(negedge clk); chk("after release q1", longint'(q0), 11); chk("after release v1", out_valid0, 1); tick();
        @(negedge clk); chk("after release q2", longint'(q0), 13); chk("after release v2", out_valid0, 1); tick();
        @(negedge clk); chk("no duplicate", out_valid0, 0); tick();

        // Overflow on the 33-bit instance, in the positive and the negative direction.
`ifdef MAC_PIPE_SATURATE_EN
        ovf_run(16'h7FFF, 16'h7FFF, 64'h0FFFFFFFF, "ovf pos");
        ovf_run(16'h8000, 16'h7FFF, 64'h100000000, "ovf neg");
`else
        ovf_run(16'h7FFF, 16'h7FFF, 64'h13FFB0005, "ovf pos");
        ovf_run(16'h8000, 16'h7FFF, 64'h0C0028000, "ovf neg");
`endif

        // clr with beats in flight and another beat offered in the same cycle.
        // ovf of u1 is still set from the run above.
        drive(5, 5, 0, 0, 0); tick();
        drive(1, 1, 0, 0, 1); tick();
        drive(2, 2, 0, 0, 1); clr = 1;
        @(negedge clk);
        chk("clr in_ready", in_ready0, 0);
        chk("clr prior result", longint'(q0), 25);
        tick();
        clr = 0; in_valid = 0;
        @(negedge clk);
        chk("clr vld", out_valid0, 0);
        chk("clr q", longint'(q0), 0);
        chk("clr ovf", ovf1, 0);
        tick();
        for (int c = 0; c < 2; c++) begin
            @(negedge clk); chk("clr no output", out_valid0, 0); tick();
        end

        // sys_rst while a result is stalled at the output.
        out_ready = 0;
        drive(3, 3, 0, 0, 0); tick();
        in_valid = 0; tick();
        @(negedge clk); chk("pre-rst vld", out_valid0, 1); chk("pre-rst q", longint'(q0), 9); tick();
        rst = 1; drive(4, 4, 0, 0, 1);
        @(negedge clk); chk("rst in_ready", in_ready0, 0); tick();
        rst = 0; in_valid = 0; out_ready = 1;
        @(negedge clk);
        chk("rst vld", out_valid0, 0);
        chk("rst q", longint'(q0), 0);
        chk("rst ovf", ovf0, 0);
        tick();
        send_wait(3, 7, 0, 0, 1, 21, "post-rst acc");
        tick(); tick();

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end
endmodule
